// File: rtl/localbus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the LocalBus. Handles
// single-beat transactions, waits out a fixed slave read latency and returns read data per master.
module localbus_arbiter #(
  parameter int XLEN     = 32,
  parameter int READ_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [2:0]      m0_we,
  output logic            m0_gnt,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_rvalid,
  input  logic            m1_req,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [2:0]      m1_we,
  output logic            m1_gnt,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_qin,
  output logic [2:0]      bus_we,
  input  logic [XLEN-1:0] bus_qout,
  output logic            busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT} state_t;

  localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

  state_t          r_state;
  state_t          w_next;
  logic            r_last_gnt;
  logic            r_owner;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_qin;
  logic [2:0]      r_we;
  logic [1:0]      r_cnt;
  logic [XLEN-1:0] r_m0_rdata;
  logic [XLEN-1:0] r_m1_rdata;
  logic            r_m0_rvalid;
  logic            r_m1_rvalid;
  logic            w_accept;
  logic            w_pick1;
  logic            w_capture;

  // On a tie the master that was not granted last wins (r_last_gnt = 1 means m1).
  assign w_pick1   = m1_req & (~m0_req | ~r_last_gnt);
  assign w_accept  = (r_state == S_IDLE) & (m0_req | m1_req);
  assign w_capture = (r_state == S_RDWAIT) & (r_cnt == 2'd0);

  always_comb begin
    w_next = r_state;
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    bus_we = 3'b000;
    busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          w_next = S_ISSUE;
          m0_gnt = ~w_pick1;
          m1_gnt = w_pick1;
        end
      end
      S_ISSUE: begin
        bus_we = r_we;
        w_next = (r_we != 3'b000) ? S_IDLE : S_RDWAIT;
      end
      S_RDWAIT: begin
        if (w_capture) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last_gnt  <= 1'b1;
      r_owner     <= 1'b0;
      r_addr      <= '0;
      r_qin       <= '0;
      r_we        <= 3'b000;
      r_cnt       <= 2'd0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_m0_rvalid <= w_capture & ~r_owner;
      r_m1_rvalid <= w_capture & r_owner;
      if (w_accept) begin
        r_owner    <= w_pick1;
        r_last_gnt <= w_pick1;
        r_addr     <= w_pick1 ? m1_addr  : m0_addr;
        r_qin      <= w_pick1 ? m1_wdata : m0_wdata;
        r_we       <= w_pick1 ? m1_we    : m0_we;
      end
      // Counter counts the remaining RDWAIT cycles before qout is sampled.
      if (r_state == S_ISSUE) begin
        r_cnt <= CNT_INIT;
      end else if ((r_state == S_RDWAIT) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_capture && !r_owner) r_m0_rdata <= bus_qout;
      if (w_capture && r_owner)  r_m1_rdata <= bus_qout;
    end
  end

  assign bus_addr  = r_addr;
  assign bus_qin   = r_qin;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;

endmodule

// File: tb/tb_localbus_arbiter.sv
// Bench for localbus_arbiter: directed vector table (READ_LAT=1), hand sequences
// for latency-4 reads and reset mid-read, then random traffic against a cycle-level model.
module tb_localbus_arbiter;
  localparam int XLEN = 32;
  localparam int NI   = 2;
  localparam logic [31:0] E = 32'hEEEE_EEEE;
  localparam logic [31:0] Z = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n    [NI];
  logic            m0_req   [NI];
  logic            m1_req   [NI];
  logic [XLEN-1:0] m0_addr  [NI];
  logic [XLEN-1:0] m0_wdata [NI];
  logic [XLEN-1:0] m1_addr  [NI];
  logic [XLEN-1:0] m1_wdata [NI];
  logic [2:0]      m0_we    [NI];
  logic [2:0]      m1_we    [NI];
  logic            m0_gnt   [NI];
  logic            m1_gnt   [NI];
  logic            m0_rvalid[NI];
  logic            m1_rvalid[NI];
  logic            busy     [NI];
  logic [XLEN-1:0] m0_rdata [NI];
  logic [XLEN-1:0] m1_rdata [NI];
  logic [XLEN-1:0] bus_addr [NI];
  logic [XLEN-1:0] bus_qin  [NI];
  logic [XLEN-1:0] bus_qout [NI];
  logic [2:0]      bus_we   [NI];

  localbus_arbiter #(.XLEN(XLEN), .READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n[0]),
    .m0_req(m0_req[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]), .m0_we(m0_we[0]),
    .m0_gnt(m0_gnt[0]), .m0_rdata(m0_rdata[0]), .m0_rvalid(m0_rvalid[0]),
    .m1_req(m1_req[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]), .m1_we(m1_we[0]),
    .m1_gnt(m1_gnt[0]), .m1_rdata(m1_rdata[0]), .m1_rvalid(m1_rvalid[0]),
    .bus_addr(bus_addr[0]), .bus_qin(bus_qin[0]), .bus_we(bus_we[0]),
    .bus_qout(bus_qout[0]), .busy(busy[0])
  );

  localbus_arbiter #(.XLEN(XLEN), .READ_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n[1]),
    .m0_req(m0_req[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]), .m0_we(m0_we[1]),
    .m0_gnt(m0_gnt[1]), .m0_rdata(m0_rdata[1]), .m0_rvalid(m0_rvalid[1]),
    .m1_req(m1_req[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]), .m1_we(m1_we[1]),
    .m1_gnt(m1_gnt[1]), .m1_rdata(m1_rdata[1]), .m1_rvalid(m1_rvalid[1]),
    .bus_addr(bus_addr[1]), .bus_qin(bus_qin[1]), .bus_we(bus_we[1]),
    .bus_qout(bus_qout[1]), .busy(busy[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic set_idle(input int i);
    m0_req[i] = 1'b0; m0_addr[i] = Z; m0_wdata[i] = Z; m0_we[i] = 3'b000;
    m1_req[i] = 1'b0; m1_addr[i] = Z; m1_wdata[i] = Z; m1_we[i] = 3'b000;
    bus_qout[i] = E;
  endtask

  task automatic reset_all();
    for (int i = 0; i < NI; i++) begin
      set_idle(i);
      rst_n[i] = 1'b0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
  endtask

  typedef struct {
    logic        r0; logic [31:0] a0; logic [31:0] d0; logic [2:0] w0;
    logic        r1; logic [31:0] a1; logic [31:0] d1; logic [2:0] w1;
    logic [31:0] qout;
    logic        g0; logic g1; logic [2:0] bwe; logic [31:0] baddr; logic [31:0] bqin;
    logic        bsy; logic rv0; logic rv1; logic [31:0] rd0; logic [31:0] rd1;
  } vec_t;

  vec_t tbl [18];

  // Reference model state for the random phase, one set per instance.
  int          lat      [NI];
  int          free_at  [NI];
  int          issue_cyc[NI];
  int          done_cyc [NI];
  int          done_m   [NI];
  int          last     [NI];
  logic [2:0]  e_we     [NI];
  logic [31:0] e_addr   [NI];
  logic [31:0] e_qin    [NI];
  logic [31:0] rd_pend  [NI];
  logic [31:0] e_rd0    [NI];
  logic [31:0] e_rd1    [NI];
  bit          pend0    [NI];
  bit          pend1    [NI];

  initial begin
    int   ngr;
    logic [1:0] xg;
    bit   idle;
    bit   acc;
    int   win;
    logic [2:0] xwe;

    // ---------------- vector table (READ_LAT = 1 instance) ----------------
    for (int k = 0; k < 5; k++)
      tbl[k] = '{1'b0, Z, Z, 3'd0, 1'b0, Z, Z, 3'd0, E,
                 1'b0, 1'b0, 3'd0, Z, Z, 1'b0, 1'b0, 1'b0, Z, Z};
    tbl[5]  = '{1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, Z, Z, 3'd0, E,
                1'b1, 1'b0, 3'd0, Z, Z, 1'b0, 1'b0, 1'b0, Z, Z};
    tbl[6]  = '{1'b0, Z, Z, 3'd0, 1'b0, Z, Z, 3'd0, E,
                1'b0, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, Z, Z};
    tbl[7]  = '{1'b0, Z, Z, 3'd0, 1'b0, Z, Z, 3'd0, E,
                1'b0, 1'b0, 3'd0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, Z, Z};
    tbl[8]  = '{1'b0, Z, Z, 3'd0, 1'b1, 32'h20, 32'hCAFE0001, 3'd0, E,
                1'b0, 1'b1, 3'd0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, Z, Z};
    tbl[9]  = '{1'b0, Z, Z, 3'd0, 1'b0, Z, Z, 3'd0, E,
                1'b0, 1'b0, 3'd0, 32'h20, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, Z, Z};
    tbl[10] = '{1'b0, Z, Z, 3'd0, 1'b0, Z, Z, 3'd0, 32'h12345678,
                1'b0, 1'b0, 3'd0, 32'h20, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, Z, Z};
    tbl[11] = '{1'b0, Z, Z, 3'd0, 1'b0, Z, Z, 3'd0, E,
                1'b0, 1'b0, 3'd0, 32'h20, 32'hCAFE0001, 1'b0, 1'b0, 1'b1, Z, 32'h12345678};
    tbl[12] = '{1'b1, 32'h30, Z, 3'd0, 1'b1, 32'h40, 32'h0BADF00D, 3'b111, E,
                1'b1, 1'b0, 3'd0, 32'h20, 32'hCAFE0001, 1'b0, 1'b0, 1'b0, Z, 32'h12345678};
    tbl[13] = '{1'b0, Z, Z, 3'd0, 1'b1, 32'h40, 32'h0BADF00D, 3'b111, E,
                1'b0, 1'b0, 3'd0, 32'h30, Z, 1'b1, 1'b0, 1'b0, Z, 32'h12345678};
    tbl[14] = '{1'b0, Z, Z, 3'd0, 1'b1, 32'h40, 32'h0BADF00D, 3'b111, 32'hA5A5A5A5,
                1'b0, 1'b0, 3'd0, 32'h30, Z, 1'b1, 1'b0, 1'b0, Z, 32'h12345678};
    tbl[15] = '{1'b0, Z, Z, 3'd0, 1'b1, 32'h40, 32'h0BADF00D, 3'b111, E,
                1'b0, 1'b1, 3'd0, 32'h30, Z, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h12345678};
    tbl[16] = '{1'b0, Z, Z, 3'd0, 1'b0, Z, Z, 3'd0, E,
                1'b0, 1'b0, 3'b111, 32'h40, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h12345678};
    tbl[17] = '{1'b0, Z, Z, 3'd0, 1'b0, Z, Z, 3'd0, E,
                1'b0, 1'b0, 3'd0, 32'h40, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h12345678};

    reset_all();
    for (int k = 0; k < 18; k++) begin
      m0_req[0] = tbl[k].r0; m0_addr[0] = tbl[k].a0; m0_wdata[0] = tbl[k].d0; m0_we[0] = tbl[k].w0;
      m1_req[0] = tbl[k].r1; m1_addr[0] = tbl[k].a1; m1_wdata[0] = tbl[k].d1; m1_we[0] = tbl[k].w1;
      bus_qout[0] = tbl[k].qout;
      @(negedge clk);
      chk($sformatf("tbl%0d.m0_gnt", k),    32'(m0_gnt[0]),    32'(tbl[k].g0));
      chk($sformatf("tbl%0d.m1_gnt", k),    32'(m1_gnt[0]),    32'(tbl[k].g1));
      chk($sformatf("tbl%0d.bus_we", k),    32'(bus_we[0]),    32'(tbl[k].bwe));
      chk($sformatf("tbl%0d.bus_addr", k),  bus_addr[0],       tbl[k].baddr);
      chk($sformatf("tbl%0d.bus_qin", k),   bus_qin[0],        tbl[k].bqin);
      chk($sformatf("tbl%0d.busy", k),      32'(busy[0]),      32'(tbl[k].bsy));
      chk($sformatf("tbl%0d.m0_rvalid", k), 32'(m0_rvalid[0]), 32'(tbl[k].rv0));
      chk($sformatf("tbl%0d.m1_rvalid", k), 32'(m1_rvalid[0]), 32'(tbl[k].rv1));
      chk($sformatf("tbl%0d.m0_rdata", k),  m0_rdata[0],       tbl[k].rd0);
      chk($sformatf("tbl%0d.m1_rdata", k),  m1_rdata[0],       tbl[k].rd1);
      @(posedge clk); #1;
    end

    // ---------------- READ_LAT = 4 read on m0 ----------------
    for (int k = 0; k < 8; k++) begin
      m0_req[1] = (k == 0); m0_addr[1] = 32'h44; m0_we[1] = 3'b000;
      bus_qout[1] = (k == 5) ? 32'h0F0F1234 : E;
      @(negedge clk);
      chk($sformatf("lat4.k%0d.m0_gnt", k),    32'(m0_gnt[1]),    32'(k == 0));
      chk($sformatf("lat4.k%0d.busy", k),      32'(busy[1]),      32'(k >= 1 && k <= 5));
      chk($sformatf("lat4.k%0d.bus_we", k),    32'(bus_we[1]),    32'h0);
      chk($sformatf("lat4.k%0d.m0_rvalid", k), 32'(m0_rvalid[1]), 32'(k == 6));
      chk($sformatf("lat4.k%0d.m0_rdata", k),  m0_rdata[1],       (k >= 6) ? 32'h0F0F1234 : Z);
      if (k >= 1) chk($sformatf("lat4.k%0d.bus_addr", k), bus_addr[1], 32'h44);
      @(posedge clk); #1;
    end

    // ---------------- reset during RDWAIT of an m0 read ----------------
    for (int k = 0; k < 15; k++) begin
      m0_req[1] = (k == 0); m0_addr[1] = 32'h50; m0_we[1] = 3'b000;
      m1_req[1] = (k == 4); m1_addr[1] = 32'h60; m1_we[1] = 3'b000;
      rst_n[1]  = (k != 3);
      bus_qout[1] = (k == 5) ? 32'h77777777 : ((k == 9) ? 32'h600D600D : E);
      @(negedge clk);
      chk($sformatf("rst.k%0d.busy", k),      32'(busy[1]),      32'((k >= 1 && k <= 3) || (k >= 5 && k <= 9)));
      chk($sformatf("rst.k%0d.m1_gnt", k),    32'(m1_gnt[1]),    32'(k == 4));
      chk($sformatf("rst.k%0d.m0_rvalid", k), 32'(m0_rvalid[1]), 32'h0);
      chk($sformatf("rst.k%0d.m1_rvalid", k), 32'(m1_rvalid[1]), 32'(k == 10));
      chk($sformatf("rst.k%0d.m1_rdata", k),  m1_rdata[1],       (k >= 10) ? 32'h600D600D : Z);
      if (k >= 4) begin
        chk($sformatf("rst.k%0d.m0_rdata", k), m0_rdata[1], Z);
        chk($sformatf("rst.k%0d.bus_addr", k), bus_addr[1], (k >= 5) ? 32'h60 : Z);
      end
      @(posedge clk); #1;
    end

    // ---------------- continuous contention: grants alternate from m0 ----------------
    reset_all();
    m0_req[0] = 1'b1; m0_addr[0] = 32'h100; m0_wdata[0] = 32'h1; m0_we[0] = 3'b001;
    m1_req[0] = 1'b1; m1_addr[0] = 32'h200; m1_wdata[0] = 32'h2; m1_we[0] = 3'b010;
    ngr = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 2 == 1)           xg = 2'b00;
      else if ((k / 2) % 2 == 0) xg = 2'b10;
      else                      xg = 2'b01;
      chk($sformatf("rr.k%0d.gnt{m0,m1}", k), 32'({m0_gnt[0], m1_gnt[0]}), 32'(xg));
      if (m0_gnt[0] || m1_gnt[0]) ngr++;
      if (m0_gnt[0]) m0_addr[0] = m0_addr[0] + 32'h4;
      if (m1_gnt[0]) m1_addr[0] = m1_addr[0] + 32'h4;
      @(posedge clk); #1;
    end
    chk("rr.grant_count", 32'(ngr), 32'd8);

    // ---------------- random traffic vs reference model ----------------
    reset_all();
    lat[0] = 1; lat[1] = 4;
    for (int i = 0; i < NI; i++) begin
      free_at[i] = 0; issue_cyc[i] = -1; done_cyc[i] = -1; done_m[i] = 0; last[i] = 1;
      e_we[i] = 3'b000; e_addr[i] = Z; e_qin[i] = Z; rd_pend[i] = Z;
      e_rd0[i] = Z; e_rd1[i] = Z; pend0[i] = 1'b0; pend1[i] = 1'b0;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NI; i++) begin
        rst_n[i] = ($urandom_range(0, 249) != 0);
        if (!pend0[i] && $urandom_range(0, 2) != 0) begin
          pend0[i] = 1'b1; m0_addr[i] = $urandom; m0_wdata[i] = $urandom;
          m0_we[i] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        end
        if (!pend1[i] && $urandom_range(0, 2) != 0) begin
          pend1[i] = 1'b1; m1_addr[i] = $urandom; m1_wdata[i] = $urandom;
          m1_we[i] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        end
        m0_req[i] = pend0[i] && rst_n[i];
        m1_req[i] = pend1[i] && rst_n[i];
        if (n == done_cyc[i]) begin
          if (done_m[i] == 0) e_rd0[i] = rd_pend[i];
          else                e_rd1[i] = rd_pend[i];
        end
        bus_qout[i] = (n == done_cyc[i] - 1) ? rd_pend[i] : $urandom;
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        idle = (n >= free_at[i]);
        acc  = idle && (m0_req[i] || m1_req[i]);
        if (m0_req[i] && m1_req[i]) win = (last[i] == 1) ? 0 : 1;
        else                        win = m1_req[i] ? 1 : 0;
        xwe = (n == issue_cyc[i]) ? e_we[i] : 3'b000;
        chk($sformatf("rnd%0d.n%0d.m0_gnt", i, n),    32'(m0_gnt[i]),    32'(acc && win == 0));
        chk($sformatf("rnd%0d.n%0d.m1_gnt", i, n),    32'(m1_gnt[i]),    32'(acc && win == 1));
        chk($sformatf("rnd%0d.n%0d.bus_we", i, n),    32'(bus_we[i]),    32'(xwe));
        chk($sformatf("rnd%0d.n%0d.bus_addr", i, n),  bus_addr[i],       e_addr[i]);
        chk($sformatf("rnd%0d.n%0d.bus_qin", i, n),   bus_qin[i],        e_qin[i]);
        chk($sformatf("rnd%0d.n%0d.busy", i, n),      32'(busy[i]),      32'(!idle));
        chk($sformatf("rnd%0d.n%0d.m0_rvalid", i, n), 32'(m0_rvalid[i]), 32'(n == done_cyc[i] && done_m[i] == 0));
        chk($sformatf("rnd%0d.n%0d.m1_rvalid", i, n), 32'(m1_rvalid[i]), 32'(n == done_cyc[i] && done_m[i] == 1));
        chk($sformatf("rnd%0d.n%0d.m0_rdata", i, n),  m0_rdata[i],       e_rd0[i]);
        chk($sformatf("rnd%0d.n%0d.m1_rdata", i, n),  m1_rdata[i],       e_rd1[i]);
        if (!rst_n[i]) begin
          free_at[i] = n + 1; last[i] = 1; issue_cyc[i] = -1; done_cyc[i] = -1;
          e_addr[i] = Z; e_qin[i] = Z; e_rd0[i] = Z; e_rd1[i] = Z;
        end else if (acc) begin
          last[i]      = win;
          issue_cyc[i] = n + 1;
          e_we[i]      = (win == 1) ? m1_we[i]    : m0_we[i];
          e_addr[i]    = (win == 1) ? m1_addr[i]  : m0_addr[i];
          e_qin[i]     = (win == 1) ? m1_wdata[i] : m0_wdata[i];
          if (e_we[i] != 3'b000) begin
            free_at[i] = n + 2;
          end else begin
            free_at[i]  = n + 2 + lat[i];
            done_cyc[i] = n + 2 + lat[i];
            done_m[i]   = win;
            rd_pend[i]  = $urandom;
          end
          if (win == 1) pend1[i] = 1'b0;
          else          pend0[i] = 1'b0;
        end
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
